vm_multi_ctrl: RTL and testbench
================================

# vm_multi_ctrl

Parametrised vending-machine controller; the next generation of the single-product-table controller. Item count, stock depth, price width and watchdog length are parameters. Adds a credit accumulator, explicit user cancel and refund, and single-cycle change output. Per-item stock and price tables are restocked through the supplier interface. Sits between the front-panel coin/button logic and the dispenser/change-return mechanics.

## Interface
- NUM_ITEMS, 8: number of products; item index width IW = $clog2(NUM_ITEMS)
- CNT_W, 4: stock counter width per item
- MAX_STOCK, 15: highest legal stock per item (≤ 2^CNT_W−1)
- COST_W, 8: price width, units of $0.01
- BAL_W, 16: credit/balance width
- TIMEOUT, 512: watchdog length in cycles
- clk  in  1  single clock, rising edge
- hrst  in  1  asynchronous active-high reset
- srst  in  1  synchronous soft reset; refunds credit, keeps tables
- coins  in  2  00 none, 01 nickel (5), 10 dime (10), 11 quarter (25)
- sel_valid  in  1  user item request strobe
- sel_item  in  IW  requested item
- select  in  1  user "buy" press
- cancel  in  1  user abort/refund
- sup_valid  in  1  supplier update strobe
- sup_item  in  IW  supplier item index
- sup_count  in  CNT_W  units to add
- sup_cost  in  COST_W  new price; 0 = keep price
- product  out  IW  dispensed item index
- product_valid  out  1  one-cycle dispense pulse
- status  out  2  00 NONE, 01 AVAILABLE, 10 OUT_OF_STOCK, 11 ERROR
- info  out  COST_W  price, then remaining amount due
- balance  out  BAL_W  change amount
- change_valid  out  1  one-cycle change pulse

## Operation
- States: IDLE, CHECK, COLLECT, VEND, CHANGE, RESTOCK.
- IDLE:
  - sup_valid has priority → RESTOCK.
  - Else sel_valid → latch sel_item, → CHECK.
  - sel_item ≥ NUM_ITEMS is ignored.
- CHECK (one cycle):
  - stock≠0 and price≠0 → status AVAILABLE, info=price, watchdog loaded, → COLLECT.
  - Otherwise → status OUT_OF_STOCK for one cycle, → IDLE.
- COLLECT:
  - Nonzero coins adds its value to credit, saturating at 2^BAL_W−1, and reloads the watchdog.
  - info = price − credit, floored at 0.
  - select with credit ≥ price → VEND.
  - select with credit < price → ignored; stay in COLLECT.
  - cancel, srst, or watchdog expiry → CHANGE.
  - Precedence: srst > cancel > select > coin.
  - A coin in the same cycle as select is credited before the compare.
- VEND (one cycle): product=latched item, product_valid=1, stock −1, credit −= price, → CHANGE.
- CHANGE (one cycle): balance=credit, change_valid=1 even when credit is 0, credit cleared, → IDLE.
- RESTOCK, per cycle with sup_valid=1:
  - stock+sup_count > MAX_STOCK (compared at CNT_W+1 bits) → status ERROR for that cycle; that item's stock is unchanged.
  - Otherwise stock += sup_count.
  - Price is updated when sup_cost≠0, independent of the stock check.
  - sup_valid=0 → IDLE.
- srst in IDLE, CHECK or RESTOCK → IDLE with no change pulse. Tables are preserved.

## Timing
- All outputs are registered and reflect the state/decision of the previous cycle.
- sel_valid sampled at edge N → CHECK during N..N+1 → status/info visible after edge N+1.
- select sampled at edge M with sufficient credit:
  - product_valid high after edge M+1 for one cycle.
  - change_valid high after edge M+2 for one cycle.
- product, balance and status hold their values only during their pulse cycle. Outside it they are 0, except info/status while in COLLECT.
- Watchdog expires TIMEOUT cycles after the last load with no coin.
- hrst asserted at any time clears immediately, without waiting for a clock edge:
  - every output to 0;
  - state to IDLE;
  - credit, stock and prices to 0.
- hrst mid-COLLECT loses credit; no refund pulse.

## Structure
- Shared package vm_multi_pkg holds:
  - state enum;
  - status_t enum;
  - coin_t enum;
  - coin value constants 5/10/25;
  - the function mapping coin_t to value.
- Sub-module vm_watchdog holds the TIMEOUT down-counter with load/enable and expiry output.
- Stock and price tables are register arrays inside the controller.

## Test plan
- Restock item 2 with count 5, cost 75. Select 2, insert quarter ×3, select → product=2, product_valid pulse, balance=0 with change_valid, stock[2]=4.
- Same item, quarter ×4 then select → balance=25. info steps 75→50→25→0→0.
- Select an item with stock 0 → one-cycle OUT_OF_STOCK, back in IDLE, no change pulse.
- Stock 12, restock +5 → ERROR, stock stays 12. A further +3 → stock 15, status NONE.
- Insert dime, idle TIMEOUT cycles → change_valid with balance=10. cancel after nickel → balance=5.
- hrst asynchronously mid-COLLECT with credit 35 → outputs 0 before the next edge, state IDLE, no change pulse.

Source files
------------

// File: rtl/vm_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm_multi_pkg
// Brief    : Shared types, coin values and coin decode for vm_multi_ctrl
// Revision : 1.0
// ============================================================================
package vm_multi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_VEND    = 3'd3,
        ST_CHANGE  = 3'd4,
        ST_RESTOCK = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        STAT_NONE         = 2'b00,
        STAT_AVAILABLE    = 2'b01,
        STAT_OUT_OF_STOCK = 2'b10,
        STAT_ERROR        = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    localparam logic [4:0] c_nickel_val  = 5'd5;
    localparam logic [4:0] c_dime_val    = 5'd10;
    localparam logic [4:0] c_quarter_val = 5'd25;

    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            COIN_NICKEL:  coin_value = c_nickel_val;
            COIN_DIME:    coin_value = c_dime_val;
            COIN_QUARTER: coin_value = c_quarter_val;
            default:      coin_value = 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vm_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : vm_watchdog
// Brief    : Inactivity down-counter; expired_o rises TIMEOUT cycles after load
// Revision : 1.0
// ============================================================================
module vm_watchdog #(
    parameter int TIMEOUT = 512
) (
    input  logic clk,
    input  logic hrst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(TIMEOUT - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/vm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vm_multi_ctrl
// Brief    : Multi-item vending controller with credit, refund and restocking
// Revision : 1.0
// ============================================================================
module vm_multi_ctrl
    import vm_multi_pkg::*;
#(
    parameter int NUM_ITEMS = 8,
    parameter int CNT_W     = 4,
    parameter int MAX_STOCK = 15,
    parameter int COST_W    = 8,
    parameter int BAL_W     = 16,
    parameter int TIMEOUT   = 512,
    localparam int IW       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic              clk,
    input  logic              hrst,
    input  logic              srst,
    input  logic [1:0]        coins,
    input  logic              sel_valid,
    input  logic [IW-1:0]     sel_item,
    input  logic              select,
    input  logic              cancel,
    input  logic              sup_valid,
    input  logic [IW-1:0]     sup_item,
    input  logic [CNT_W-1:0]  sup_count,
    input  logic [COST_W-1:0] sup_cost,
    output logic [IW-1:0]     product,
    output logic              product_valid,
    output logic [1:0]        status,
    output logic [COST_W-1:0] info,
    output logic [BAL_W-1:0]  balance,
    output logic              change_valid
);
    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_CHECK   = ST_CHECK;
    localparam logic [2:0] S_COLLECT = ST_COLLECT;
    localparam logic [2:0] S_VEND    = ST_VEND;
    localparam logic [2:0] S_CHANGE  = ST_CHANGE;
    localparam logic [2:0] S_RESTOCK = ST_RESTOCK;

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     item_q, item_d;
    logic [BAL_W-1:0]  credit_q, credit_d;
    logic [CNT_W-1:0]  stock_q [NUM_ITEMS];
    logic [COST_W-1:0] price_q [NUM_ITEMS];

    logic [IW-1:0]     product_q, product_d;
    logic              product_valid_q, product_valid_d;
    logic [1:0]        status_q, status_d;
    logic [COST_W-1:0] info_q, info_d;
    logic [BAL_W-1:0]  balance_q, balance_d;
    logic              change_valid_q, change_valid_d;

    logic              wd_load, wd_en, wd_expired;

    logic [4:0]        coin_val;
    logic [BAL_W:0]    credit_sum;
    logic [BAL_W-1:0]  credit_plus;
    logic [COST_W-1:0] cur_price;
    logic [CNT_W-1:0]  cur_stock;
    logic [BAL_W-1:0]  price_ext;
    logic [COST_W-1:0] due_plus;
    logic              sel_ok, sup_ok;
    logic [CNT_W:0]    rs_sum;
    logic              rs_ovf, rs_wr;

    assign coin_val    = coin_value(coin_t'(coins));
    assign credit_sum  = {1'b0, credit_q} + (BAL_W + 1)'(coin_val);
    assign credit_plus = credit_sum[BAL_W] ? '1 : credit_sum[BAL_W-1:0];
    assign cur_price   = price_q[item_q];
    assign cur_stock   = stock_q[item_q];
    assign price_ext   = BAL_W'(cur_price);
    // Credit below price always fits in COST_W bits, so the narrow subtract is exact
    assign due_plus    = (credit_plus >= price_ext) ? '0 : cur_price - credit_plus[COST_W-1:0];

    assign sel_ok = (32'(sel_item) < 32'(NUM_ITEMS));
    assign sup_ok = (32'(sup_item) < 32'(NUM_ITEMS));
    assign rs_sum = {1'b0, stock_q[sup_item]} + {1'b0, sup_count};
    assign rs_ovf = rs_sum > (CNT_W + 1)'(MAX_STOCK);
    assign rs_wr  = (state_q == S_RESTOCK) && sup_valid && !srst && sup_ok;

    vm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .hrst      (hrst),
        .load_i    (wd_load),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d         = state_q;
        item_d          = item_q;
        credit_d        = credit_q;
        product_d       = '0;
        product_valid_d = 1'b0;
        status_d        = STAT_NONE;
        info_d          = '0;
        balance_d       = '0;
        change_valid_d  = 1'b0;
        wd_load         = 1'b0;
        wd_en           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (srst) begin
                    state_d = S_IDLE;
                end else if (sup_valid) begin
                    state_d = S_RESTOCK;
                end else if (sel_valid && sel_ok) begin
                    item_d  = sel_item;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (srst) begin
                    state_d = S_IDLE;
                end else if ((cur_stock != '0) && (cur_price != '0)) begin
                    status_d = STAT_AVAILABLE;
                    info_d   = cur_price;
                    wd_load  = 1'b1;
                    state_d  = S_COLLECT;
                end else begin
                    status_d = STAT_OUT_OF_STOCK;
                    state_d  = S_IDLE;
                end
            end
            S_COLLECT: begin
                wd_en = 1'b1;
                // Aborts drop any coin presented in the same cycle
                if (srst || cancel || wd_expired) begin
                    state_d = S_CHANGE;
                end else begin
                    credit_d = credit_plus;
                    wd_load  = (coin_val != '0);
                    if (select && (credit_plus >= price_ext)) begin
                        state_d = S_VEND;
                    end else begin
                        status_d = STAT_AVAILABLE;
                        info_d   = due_plus;
                    end
                end
            end
            S_VEND: begin
                product_d       = item_q;
                product_valid_d = 1'b1;
                credit_d        = credit_q - price_ext;
                state_d         = S_CHANGE;
            end
            S_CHANGE: begin
                balance_d      = credit_q;
                change_valid_d = 1'b1;
                credit_d       = '0;
                state_d        = S_IDLE;
            end
            S_RESTOCK: begin
                if (srst || !sup_valid) begin
                    state_d = S_IDLE;
                end else if (sup_ok && rs_ovf) begin
                    status_d = STAT_ERROR;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            state_q         <= S_IDLE;
            item_q          <= '0;
            credit_q        <= '0;
            product_q       <= '0;
            product_valid_q <= 1'b0;
            status_q        <= STAT_NONE;
            info_q          <= '0;
            balance_q       <= '0;
            change_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            item_q          <= item_d;
            credit_q        <= credit_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
            status_q        <= status_d;
            info_q          <= info_d;
            balance_q       <= balance_d;
            change_valid_q  <= change_valid_d;
        end
    end

    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= '0;
                price_q[i] <= '0;
            end
        end else begin
            if (state_q == S_VEND) begin
                stock_q[item_q] <= cur_stock - 1'b1;
            end
            if (rs_wr) begin
                if (!rs_ovf) begin
                    stock_q[sup_item] <= rs_sum[CNT_W-1:0];
                end
                if (sup_cost != '0) begin
                    price_q[sup_item] <= sup_cost;
                end
            end
        end
    end

    assign product       = product_q;
    assign product_valid = product_valid_q;
    assign status        = status_q;
    assign info          = info_q;
    assign balance       = balance_q;
    assign change_valid  = change_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm_multi_ctrl
// Brief    : Self-checking bench for vm_multi_ctrl against a transaction model
// Revision : 1.0
// ============================================================================
module tb_vm_multi_ctrl;
    localparam int NUM_ITEMS = 8;
    localparam int IW        = 3;
    localparam int CNT_W     = 4;
    localparam int MAX_STOCK = 15;
    localparam int COST_W    = 8;
    localparam int BAL_W     = 16;
    localparam int TIMEOUT   = 512;

    localparam int ACT_SELECT  = 0;
    localparam int ACT_CANCEL  = 1;
    localparam int ACT_SRST    = 2;
    localparam int ACT_TIMEOUT = 3;

    logic              clk = 1'b0;
    logic              hrst, srst, sel_valid, select, cancel, sup_valid;
    logic [1:0]        coins;
    logic [IW-1:0]     sel_item, sup_item;
    logic [CNT_W-1:0]  sup_count;
    logic [COST_W-1:0] sup_cost;
    logic [IW-1:0]     product;
    logic              product_valid, change_valid;
    logic [1:0]        status;
    logic [COST_W-1:0] info;
    logic [BAL_W-1:0]  balance;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int load_cyc;
    int m_stock [NUM_ITEMS];
    int m_price [NUM_ITEMS];

    vm_multi_ctrl #(
        .NUM_ITEMS (NUM_ITEMS),
        .CNT_W     (CNT_W),
        .MAX_STOCK (MAX_STOCK),
        .COST_W    (COST_W),
        .BAL_W     (BAL_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .hrst          (hrst),
        .srst          (srst),
        .coins         (coins),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .select        (select),
        .cancel        (cancel),
        .sup_valid     (sup_valid),
        .sup_item      (sup_item),
        .sup_count     (sup_count),
        .sup_cost      (sup_cost),
        .product       (product),
        .product_valid (product_valid),
        .status        (status),
        .info          (info),
        .balance       (balance),
        .change_valid  (change_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_val(input int c);
        case (c)
            1: return 5;
            2: return 10;
            3: return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int due(input int price, input int credit);
        return (credit >= price) ? 0 : price - credit;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_product"}, 32'(product), 0);
        check_eq({tag, "_pv"}, 32'(product_valid), 0);
        check_eq({tag, "_status"}, 32'(status), 0);
        check_eq({tag, "_info"}, 32'(info), 0);
        check_eq({tag, "_balance"}, 32'(balance), 0);
        check_eq({tag, "_cv"}, 32'(change_valid), 0);
    endtask

    task automatic sup_open();
        sup_valid = 1'b1; sup_item = '0; sup_count = '0; sup_cost = '0;
        step();
        check_eq("rs_entry_status", 32'(status), 0);
    endtask

    task automatic sup_beat(input int item, input int cnt, input int cost);
        bit ovf;
        sup_item = IW'(item); sup_count = CNT_W'(cnt); sup_cost = COST_W'(cost);
        step();
        ovf = (m_stock[item] + cnt) > MAX_STOCK;
        check_eq("rs_status", 32'(status), ovf ? 3 : 0);
        if (!ovf) m_stock[item] += cnt;
        if (cost != 0) m_price[item] = cost;
    endtask

    task automatic sup_close();
        sup_valid = 1'b0; sup_item = '0; sup_count = '0; sup_cost = '0;
        step();
        check_eq("rs_exit_status", 32'(status), 0);
    endtask

    task automatic purchase(input int item, input int ncoins, input int fixed_coin,
                            input int action, input bit coin_on_sel);
        int  price, credit, c, k, act;
        bit  seen;
        act    = action;
        price  = m_price[item];
        credit = 0;
        sel_valid = 1'b1; sel_item = IW'(item);
        step();
        sel_valid = 1'b0;
        step();
        if (m_stock[item] == 0 || price == 0) begin
            check_eq("oos_status", 32'(status), 2);
            check_eq("oos_info", 32'(info), 0);
            step();
            check_eq("oos_clear", 32'(status), 0);
            check_eq("oos_nochg", 32'(change_valid), 0);
            return;
        end
        check_eq("avail_status", 32'(status), 1);
        check_eq("avail_info", 32'(info), 32'(price));
        load_cyc = cyc;
        for (int i = 0; i < ncoins; i++) begin
            if (fixed_coin == 0 && $urandom_range(0, 3) == 0) begin
                step();
                check_eq("gap_info", 32'(info), 32'(due(price, credit)));
            end
            c = (fixed_coin != 0) ? fixed_coin : int'($urandom_range(1, 3));
            coins = 2'(c);
            credit += coin_val(c);
            step();
            coins = 2'b00;
            load_cyc = cyc;
            check_eq("coin_info", 32'(info), 32'(due(price, credit)));
            check_eq("coin_status", 32'(status), 1);
        end
        if (act == ACT_SELECT) begin
            if (coin_on_sel) begin
                c = int'($urandom_range(1, 3));
                coins = 2'(c);
                credit += coin_val(c);
            end
            select = 1'b1;
            step();
            select = 1'b0; coins = 2'b00;
            if (credit >= price) begin
                check_eq("sel_status", 32'(status), 0);
                check_eq("sel_pv_early", 32'(product_valid), 0);
                step();
                check_eq("vend_pv", 32'(product_valid), 1);
                check_eq("vend_product", 32'(product), 32'(item));
                check_eq("vend_cv_early", 32'(change_valid), 0);
                step();
                check_eq("chg_cv", 32'(change_valid), 1);
                check_eq("chg_balance", 32'(balance), 32'(credit - price));
                check_eq("chg_pv_clear", 32'(product_valid), 0);
                m_stock[item]--;
                step();
                check_eq("post_cv", 32'(change_valid), 0);
                check_eq("post_balance", 32'(balance), 0);
                return;
            end
            check_eq("short_status", 32'(status), 1);
            check_eq("short_info", 32'(info), 32'(due(price, credit)));
            check_eq("short_pv", 32'(product_valid), 0);
            act = ACT_CANCEL;
        end
        if (act == ACT_TIMEOUT) begin
            seen = 1'b0;
            k    = 0;
            while (!seen && k < TIMEOUT + 20) begin
                step();
                k++;
                if (change_valid) seen = 1'b1;
            end
            check_eq("wd_seen", 32'(seen), 1);
            check_eq("wd_latency", 32'(cyc - load_cyc), 32'(TIMEOUT + 1));
            check_eq("wd_balance", 32'(balance), 32'(credit));
        end else begin
            if (act == ACT_CANCEL) cancel = 1'b1;
            else srst = 1'b1;
            step();
            cancel = 1'b0; srst = 1'b0;
            check_eq("abort_status", 32'(status), 0);
            check_eq("abort_cv_early", 32'(change_valid), 0);
            step();
            check_eq("refund_cv", 32'(change_valid), 1);
            check_eq("refund_balance", 32'(balance), 32'(credit));
        end
        step();
        check_eq("post_cv", 32'(change_valid), 0);
        check_eq("post_status", 32'(status), 0);
    endtask

    initial begin
        hrst = 1'b1; srst = 1'b0; coins = 2'b00; sel_valid = 1'b0; sel_item = '0;
        select = 1'b0; cancel = 1'b0; sup_valid = 1'b0; sup_item = '0;
        sup_count = '0; sup_cost = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            m_stock[i] = 0;
            m_price[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        hrst = 1'b0;
        step();
        check_idle_outputs("post_reset");

        // Restock item 2, exact-change buy, then overpay buy
        sup_open();
        sup_beat(2, 5, 75);
        sup_close();
        purchase(2, 3, 3, ACT_SELECT, 1'b0);
        purchase(2, 4, 3, ACT_SELECT, 1'b0);

        purchase(5, 0, 0, ACT_SELECT, 1'b0);

        // Overflow restock keeps stock, then fill exactly to MAX_STOCK
        sup_open();
        sup_beat(3, 12, 40);
        sup_beat(3, 5, 0);
        sup_beat(3, 3, 0);
        sup_close();

        purchase(3, 1, 2, ACT_TIMEOUT, 1'b0);
        purchase(3, 1, 1, ACT_CANCEL, 1'b0);
        purchase(3, 2, 2, ACT_SRST, 1'b0);

        // Asynchronous hard reset mid-collect with 35 credited
        sel_valid = 1'b1; sel_item = IW'(2);
        step();
        sel_valid = 1'b0;
        step();
        coins = 2'b11;
        step();
        coins = 2'b10;
        step();
        coins = 2'b00;
        check_eq("hr_pre_info", 32'(info), 32'(due(m_price[2], 35)));
        check_eq("hr_pre_status", 32'(status), 1);
        #2 hrst = 1'b1;
        #1;
        check_idle_outputs("hrst_async");
        #2 hrst = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            m_stock[i] = 0;
            m_price[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("hr_no_refund", 32'(change_valid), 0);
        end
        purchase(2, 0, 0, ACT_SELECT, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                sup_open();
                for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                    sup_beat(int'($urandom_range(0, NUM_ITEMS - 1)),
                             int'($urandom_range(0, 8)),
                             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 200)));
                end
                sup_close();
            end else begin
                purchase(int'($urandom_range(0, NUM_ITEMS - 1)),
                         int'($urandom_range(0, 8)), 0,
                         ($urandom_range(0, 4) < 3) ? ACT_SELECT
                             : (($urandom_range(0, 1) == 0) ? ACT_CANCEL : ACT_SRST),
                         1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
